// File: rtl/esc_ramp_seq.sv
// esc_ramp_seq: arms four ESC channels on a Wishbone PWM peripheral, ramps each
// motor duty toward its clamped target by at most STEP per ramp tick, and
// zeroes all duties on disarm. An unacknowledged write latches a sticky fault.
//
// Ports:
//   clk, reset           clock; synchronous active-high reset
//   arm                  level, 1 = run motors, 0 = disarm
//   tgt_valid, tgt[127:0] capture four 32-bit target duties (motor n at [32n+31:32n])
//   wbm_*                single-write Wishbone master
//   armed                high in RUN and UPDATE
//   busy                 high while a Wishbone cycle is open
//   fault                sticky ack-timeout flag, cleared only by reset
//
// state   | meaning
// IDLE    | motors stopped, waiting for arm
// INIT    | writing period, then MIN_DUTY to all four duties
// RUN     | armed, waiting for a ramp tick
// UPDATE  | writing the duties that changed on this tick
// DISARM  | writing 0 to all four duties
// FAULT   | slave failed to ack; bus parked until reset
module esc_ramp_seq #(
   parameter logic [31:0] PWM_BASE   = 32'h0000_0000,
   parameter int unsigned PERIOD_US  = 20000,
   parameter int unsigned MIN_DUTY   = 1000,
   parameter int unsigned MAX_DUTY   = 2000,
   parameter int unsigned STEP       = 10,
   parameter int unsigned TICK_DIV   = 50000,
   parameter int unsigned WB_TIMEOUT = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         arm,
   input  logic         tgt_valid,
   input  logic [127:0] tgt,
   output logic         wbm_cyc_o,
   output logic         wbm_stb_o,
   output logic         wbm_we_o,
   output logic [31:0]  wbm_adr_o,
   output logic [3:0]   wbm_sel_o,
   output logic [31:0]  wbm_dat_o,
   input  logic         wbm_ack_i,
   output logic         armed,
   output logic         busy,
   output logic         fault
);
   localparam logic [31:0] MIN_D  = 32'(MIN_DUTY);
   localparam logic [31:0] MAX_D  = 32'(MAX_DUTY);
   localparam logic [31:0] STEP_D = 32'(STEP);
   localparam logic [31:0] PER_D  = 32'(PERIOD_US);
   localparam int TCW = $clog2(TICK_DIV);
   localparam int TOW = $clog2(WB_TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, INIT, RUN, UPDATE, DISARM, FAULT} state_t;

   state_t state_q, state_d;

   logic [2:0]     idx_q;
   logic [31:0]    cur_q [4];
   logic [31:0]    nxt_q [4];
   logic [31:0]    tgt_q [4];
   logic [31:0]    nxt_calc [4];
   logic           cyc_q, fault_q, tick_pend_q;
   logic [31:0]    adr_q, dat_q;
   logic [TOW-1:0] to_cnt_q;
   logic [TCW-1:0] tick_cnt_q;

   logic        ack_evt, to_evt, tick_tc;
   logic        wr_go, idx_inc, idx_clr, cur_we, cur_init, nxt_ld, tick_clr;
   logic [31:0] wr_adr, wr_dat, cur_val;

   function automatic logic [31:0] clamp(input logic [31:0] v);
      if (v < MIN_D)      return MIN_D;
      else if (v > MAX_D) return MAX_D;
      else                return v;
   endfunction

   assign ack_evt = cyc_q & wbm_ack_i;
   assign to_evt  = cyc_q & ~wbm_ack_i & (to_cnt_q == '0);
   assign tick_tc = (tick_cnt_q == TCW'(TICK_DIV - 1));

   // cur never exceeds MAX_D while running, so cur+STEP cannot wrap
   always_comb begin
      for (int n = 0; n < 4; n++) begin
         nxt_calc[n] = cur_q[n];
         if (cur_q[n] < tgt_q[n])
            nxt_calc[n] = (cur_q[n] + STEP_D < tgt_q[n]) ? cur_q[n] + STEP_D : tgt_q[n];
         else if (cur_q[n] > tgt_q[n])
            nxt_calc[n] = (cur_q[n] - tgt_q[n] > STEP_D) ? cur_q[n] - STEP_D : tgt_q[n];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      wr_go    = 1'b0;
      wr_adr   = PWM_BASE;
      wr_dat   = '0;
      idx_inc  = 1'b0;
      idx_clr  = 1'b0;
      cur_we   = 1'b0;
      cur_init = 1'b0;
      cur_val  = '0;
      nxt_ld   = 1'b0;
      tick_clr = 1'b0;
      case (state_q)
         IDLE: if (arm) begin
            state_d = INIT;
            idx_clr = 1'b1;
         end
         INIT: begin
            if (cyc_q) begin
               if (ack_evt) idx_inc = 1'b1;
            end else if (!arm) begin
               state_d = DISARM;
               idx_clr = 1'b1;
            end else if (idx_q == 3'd5) begin
               state_d  = RUN;
               cur_init = 1'b1;
            end else begin
               wr_go  = 1'b1;
               wr_adr = PWM_BASE + {27'd0, idx_q, 2'b00};
               wr_dat = (idx_q == 3'd0) ? PER_D : MIN_D;
            end
         end
         RUN: begin
            if (!arm) begin
               state_d = DISARM;
               idx_clr = 1'b1;
            end else if (tick_pend_q) begin
               state_d  = UPDATE;
               nxt_ld   = 1'b1;
               tick_clr = 1'b1;
               idx_clr  = 1'b1;
            end
         end
         UPDATE: begin
            if (cyc_q) begin
               if (ack_evt) begin
                  cur_we  = 1'b1;
                  cur_val = nxt_q[idx_q[1:0]];
                  idx_inc = 1'b1;
               end
            end else if (!arm) begin
               state_d = DISARM;
               idx_clr = 1'b1;
            end else if (idx_q == 3'd4) begin
               state_d = RUN;
            end else if (nxt_q[idx_q[1:0]] == cur_q[idx_q[1:0]]) begin
               idx_inc = 1'b1;
            end else begin
               wr_go  = 1'b1;
               wr_adr = PWM_BASE + 32'd4 + {28'd0, idx_q[1:0], 2'b00};
               wr_dat = nxt_q[idx_q[1:0]];
            end
         end
         DISARM: begin
            if (cyc_q) begin
               if (ack_evt) begin
                  cur_we  = 1'b1;
                  idx_inc = 1'b1;
               end
            end else if (idx_q == 3'd4) begin
               state_d = IDLE;
            end else begin
               wr_go  = 1'b1;
               wr_adr = PWM_BASE + 32'd4 + {28'd0, idx_q[1:0], 2'b00};
            end
         end
         default: ;
      endcase
      if (to_evt) state_d = FAULT;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         idx_q       <= '0;
         cyc_q       <= 1'b0;
         adr_q       <= '0;
         dat_q       <= '0;
         to_cnt_q    <= '0;
         fault_q     <= 1'b0;
         tick_cnt_q  <= '0;
         tick_pend_q <= 1'b0;
         for (int n = 0; n < 4; n++) begin
            cur_q[n] <= '0;
            nxt_q[n] <= '0;
            tgt_q[n] <= MIN_D;
         end
      end else begin
         tick_cnt_q <= tick_tc ? '0 : tick_cnt_q + 1'b1;
         // a fresh terminal count wins over consumption so no tick is lost
         if (tick_tc)       tick_pend_q <= 1'b1;
         else if (tick_clr) tick_pend_q <= 1'b0;

         if (idx_clr)      idx_q <= '0;
         else if (idx_inc) idx_q <= idx_q + 3'd1;

         for (int n = 0; n < 4; n++) begin
            if (cur_init) cur_q[n] <= MIN_D;
            if (nxt_ld)   nxt_q[n] <= nxt_calc[n];
            if (tgt_valid && state_q != FAULT) tgt_q[n] <= clamp(tgt[32*n +: 32]);
         end
         if (cur_we) cur_q[idx_q[1:0]] <= cur_val;

         if (wr_go) begin
            cyc_q    <= 1'b1;
            adr_q    <= wr_adr;
            dat_q    <= wr_dat;
            to_cnt_q <= TOW'(WB_TIMEOUT - 1);
         end else if (cyc_q) begin
            if (ack_evt || to_evt) cyc_q <= 1'b0;
            else                   to_cnt_q <= to_cnt_q - 1'b1;
         end
         if (to_evt) fault_q <= 1'b1;
      end
   end

   assign wbm_cyc_o = cyc_q;
   assign wbm_stb_o = cyc_q;
   assign wbm_we_o  = cyc_q;
   assign wbm_sel_o = cyc_q ? 4'hF : 4'h0;
   assign wbm_adr_o = adr_q;
   assign wbm_dat_o = dat_q;
   assign armed     = (state_q == RUN) || (state_q == UPDATE);
   assign busy      = cyc_q;
   assign fault     = fault_q;
endmodule

// File: tb/tb_esc_ramp_seq.sv
module tb_esc_ramp_seq;
   localparam logic [31:0] BASE = 32'h8000_0000;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         arm = 1'b0;
   logic         tgt_valid = 1'b0;
   logic [127:0] tgt = '0;
   logic         wbm_cyc_o, wbm_stb_o, wbm_we_o;
   logic [31:0]  wbm_adr_o, wbm_dat_o;
   logic [3:0]   wbm_sel_o;
   logic         wbm_ack_i = 1'b0;
   logic         armed, busy, fault;
   logic         ack_en = 1'b1;

   int checks = 0;
   int errors = 0;
   int proto_err = 0;
   logic [31:0] qa[$];
   logic [31:0] qd[$];

   always #5 clk = ~clk;

   esc_ramp_seq #(
      .PWM_BASE(BASE), .PERIOD_US(20000), .MIN_DUTY(1000), .MAX_DUTY(2000),
      .STEP(10), .TICK_DIV(100), .WB_TIMEOUT(16)
   ) dut (
      .clk(clk), .reset(reset), .arm(arm), .tgt_valid(tgt_valid), .tgt(tgt),
      .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
      .wbm_adr_o(wbm_adr_o), .wbm_sel_o(wbm_sel_o), .wbm_dat_o(wbm_dat_o),
      .wbm_ack_i(wbm_ack_i), .armed(armed), .busy(busy), .fault(fault)
   );

   // slave: ack one cycle after stb is seen
   always @(posedge clk) begin
      if (reset) wbm_ack_i <= 1'b0;
      else       wbm_ack_i <= ack_en && wbm_cyc_o && wbm_stb_o && !wbm_ack_i;
   end

   // bus monitor: logs completed writes and counts handshake violations
   logic        prev_stb = 1'b0, prev_done = 1'b0;
   logic [31:0] prev_adr = '0, prev_dat = '0;
   always @(negedge clk) begin
      if (wbm_stb_o) begin
         if (wbm_we_o !== 1'b1 || wbm_sel_o !== 4'hF) proto_err++;
         if (prev_stb && !prev_done && (wbm_adr_o !== prev_adr || wbm_dat_o !== prev_dat)) proto_err++;
         if (prev_done) proto_err++;
      end
      if (wbm_cyc_o !== wbm_stb_o || busy !== wbm_cyc_o) proto_err++;
      prev_done = wbm_cyc_o && wbm_stb_o && wbm_ack_i;
      if (prev_done) begin
         qa.push_back(wbm_adr_o);
         qd.push_back(wbm_dat_o);
      end
      prev_stb = wbm_stb_o;
      prev_adr = wbm_adr_o;
      prev_dat = wbm_dat_o;
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_tgt(input logic [31:0] m0, input logic [31:0] m1,
                           input logic [31:0] m2, input logic [31:0] m3);
      @(negedge clk);
      tgt = {m3, m2, m1, m0};
      tgt_valid = 1'b1;
      @(negedge clk);
      tgt_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      arm = 1'b0;
      cycles(3);
      checks++; if (wbm_cyc_o !== 1'b0) begin errors++; $display("FAIL reset_cyc got=%b exp=0", wbm_cyc_o); end
      checks++; if (wbm_stb_o !== 1'b0) begin errors++; $display("FAIL reset_stb got=%b exp=0", wbm_stb_o); end
      checks++; if (wbm_we_o !== 1'b0) begin errors++; $display("FAIL reset_we got=%b exp=0", wbm_we_o); end
      checks++; if (wbm_sel_o !== 4'h0) begin errors++; $display("FAIL reset_sel got=%h exp=0", wbm_sel_o); end
      checks++; if (wbm_adr_o !== 32'h0 || wbm_dat_o !== 32'h0) begin errors++; $display("FAIL reset_adr_dat got=%h/%h exp=0/0", wbm_adr_o, wbm_dat_o); end
      checks++; if (armed !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_armed_busy got=%b/%b exp=0/0", armed, busy); end
      checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault got=%b exp=0", fault); end
      reset = 1'b0;
      cycles(2);
   endtask

   task automatic test_init(input string tag);
      int n;
      @(negedge clk);
      qa.delete();
      qd.delete();
      arm = 1'b1;
      n = 0;
      while (armed !== 1'b1 && n < 300) begin @(negedge clk); n++; end
      checks++; if (armed !== 1'b1) begin errors++; $display("FAIL %s_armed got=%b exp=1", tag, armed); end
      checks++; if (qa.size() != 5) begin errors++; $display("FAIL %s_count got=%0d exp=5", tag, qa.size()); end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (i >= qa.size()) begin
            errors++; $display("FAIL %s_write%0d got=none exp=%h<=%0d", tag, i, BASE + 4*i, (i == 0) ? 20000 : 1000);
         end else if (qa[i] !== BASE + 32'(4*i) || qd[i] !== ((i == 0) ? 32'd20000 : 32'd1000)) begin
            errors++; $display("FAIL %s_write%0d got=%h<=%0d exp=%h<=%0d", tag, i, qa[i], qd[i], BASE + 4*i, (i == 0) ? 20000 : 1000);
         end
      end
   endtask

   task automatic test_ramp_motor0();
      logic [31:0] exp_d [3] = '{32'd1010, 32'd1020, 32'd1025};
      send_tgt(32'd1025, 32'd1000, 32'd1000, 32'd1000);
      qa.delete();
      qd.delete();
      cycles(550);
      checks++; if (qa.size() != 3) begin errors++; $display("FAIL ramp0_count got=%0d exp=3", qa.size()); end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (i >= qa.size()) begin
            errors++; $display("FAIL ramp0_write%0d got=none exp=%h<=%0d", i, BASE + 4, exp_d[i]);
         end else if (qa[i] !== BASE + 32'd4 || qd[i] !== exp_d[i]) begin
            errors++; $display("FAIL ramp0_write%0d got=%h<=%0d exp=%h<=%0d", i, qa[i], qd[i], BASE + 4, exp_d[i]);
         end
      end
      checks++; if (armed !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL ramp0_idle got armed/busy=%b/%b exp=1/0", armed, busy); end
   endtask

   task automatic ramp_motor1(input string tag, input logic [31:0] raw,
                              input logic [31:0] first, input logic [31:0] last, input bit up);
      int cnt, other, badstep;
      logic [31:0] f, l;
      send_tgt(32'd1025, raw, 32'd1000, 32'd1000);
      qa.delete();
      qd.delete();
      cycles(10600);
      cnt = 0; other = 0; badstep = 0; f = '0; l = '0;
      for (int i = 0; i < qa.size(); i++) begin
         if (qa[i] == BASE + 32'd8) begin
            if (cnt == 0) f = qd[i];
            else if (qd[i] !== (up ? l + 32'd10 : l - 32'd10)) badstep++;
            l = qd[i];
            cnt++;
         end else other++;
      end
      checks++; if (cnt != 100) begin errors++; $display("FAIL %s_count got=%0d exp=100", tag, cnt); end
      checks++; if (f !== first) begin errors++; $display("FAIL %s_first got=%0d exp=%0d", tag, f, first); end
      checks++; if (l !== last) begin errors++; $display("FAIL %s_last got=%0d exp=%0d", tag, l, last); end
      checks++; if (badstep != 0) begin errors++; $display("FAIL %s_step got=%0d bad steps exp=0", tag, badstep); end
      checks++; if (other != 0) begin errors++; $display("FAIL %s_other_motors got=%0d writes exp=0", tag, other); end
   endtask

   task automatic test_clamp();
      ramp_motor1("clamp_up", 32'd5000, 32'd1010, 32'd2000, 1'b1);
      ramp_motor1("clamp_dn", 32'd0, 32'd1990, 32'd1000, 1'b0);
   endtask

   task automatic test_disarm();
      int n;
      logic [31:0] exp_a [5];
      logic [31:0] exp_d [5];
      exp_a = '{BASE + 32'hC, BASE + 32'h4, BASE + 32'h8, BASE + 32'hC, BASE + 32'h10};
      exp_d = '{32'd1010, 32'd0, 32'd0, 32'd0, 32'd0};
      send_tgt(32'd1025, 32'd0, 32'd2000, 32'd1000);
      n = 0;
      while (!(wbm_stb_o === 1'b1 && wbm_adr_o === BASE + 32'hC) && n < 300) begin @(negedge clk); n++; end
      checks++; if (wbm_stb_o !== 1'b1) begin errors++; $display("FAIL disarm_wait got=stb %b exp=1", wbm_stb_o); end
      qa.delete();
      qd.delete();
      arm = 1'b0;
      n = 0;
      while (qa.size() < 5 && n < 300) begin @(negedge clk); n++; end
      cycles(5);
      checks++; if (qa.size() != 5) begin errors++; $display("FAIL disarm_count got=%0d exp=5", qa.size()); end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (i >= qa.size()) begin
            errors++; $display("FAIL disarm_write%0d got=none exp=%h<=%0d", i, exp_a[i], exp_d[i]);
         end else if (qa[i] !== exp_a[i] || qd[i] !== exp_d[i]) begin
            errors++; $display("FAIL disarm_write%0d got=%h<=%0d exp=%h<=%0d", i, qa[i], qd[i], exp_a[i], exp_d[i]);
         end
      end
      checks++; if (armed !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL disarm_state got armed/busy=%b/%b exp=0/0", armed, busy); end
      test_init("rearm");
   endtask

   task automatic test_timeout();
      int n, stb_cyc, late;
      n = 0;
      while (busy !== 1'b0 && n < 100) begin @(negedge clk); n++; end
      ack_en = 1'b0;
      send_tgt(32'd1025, 32'd0, 32'd2000, 32'd1100);
      n = 0;
      while (wbm_stb_o !== 1'b1 && n < 300) begin @(negedge clk); n++; end
      stb_cyc = 0;
      while (wbm_stb_o === 1'b1 && stb_cyc < 100) begin stb_cyc++; @(negedge clk); end
      checks++; if (stb_cyc != 16) begin errors++; $display("FAIL timeout_stb_len got=%0d exp=16", stb_cyc); end
      checks++; if (fault !== 1'b1) begin errors++; $display("FAIL timeout_fault got=%b exp=1", fault); end
      checks++; if (armed !== 1'b0) begin errors++; $display("FAIL timeout_armed got=%b exp=0", armed); end
      late = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (wbm_stb_o !== 1'b0) late++;
      end
      checks++; if (late != 0) begin errors++; $display("FAIL timeout_quiet got=%0d stb cycles exp=0", late); end
      checks++; if (fault !== 1'b1) begin errors++; $display("FAIL timeout_sticky got=%b exp=1", fault); end
      reset = 1'b1;
      arm = 1'b0;
      ack_en = 1'b1;
      cycles(2);
      reset = 1'b0;
      cycles(1);
      checks++; if (fault !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL timeout_reset got fault/busy=%b/%b exp=0/0", fault, busy); end
   endtask

   task automatic test_reset_midcycle();
      int n;
      ack_en = 1'b0;
      arm = 1'b1;
      n = 0;
      while (wbm_stb_o !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      checks++; if (wbm_stb_o !== 1'b1) begin errors++; $display("FAIL midreset_wait got=stb %b exp=1", wbm_stb_o); end
      ack_en = 1'b1;
      reset = 1'b1;
      arm = 1'b0;
      @(negedge clk);
      checks++; if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0) begin errors++; $display("FAIL midreset_drop got cyc/stb=%b/%b exp=0/0", wbm_cyc_o, wbm_stb_o); end
      reset = 1'b0;
      cycles(3);
   endtask

   task automatic test_protocol();
      checks++; if (proto_err != 0) begin errors++; $display("FAIL bus_protocol got=%0d violations exp=0", proto_err); end
   endtask

   initial begin
      test_reset();
      test_init("init");
      test_ramp_motor0();
      test_clamp();
      test_disarm();
      test_timeout();
      test_reset_midcycle();
      test_protocol();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
